// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder: byte/half/word loads and stores on a word-wide sync RAM
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
   parameter int         ADDR_WIDTH = 10,
   parameter logic [1:0] full_word  = 2'd0,
   parameter logic [1:0] half_word  = 2'd1,
   parameter logic [1:0] byte_word  = 2'd2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_en,
   input  logic        mem_rd_en,
   input  logic        mem_wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic [1:0]  data_length,
   input  logic        load_unsigned,
   output logic [31:0] rd_data,
   output logic        mem_ready,
   output logic        busy,
   output logic        misaligned_err
);
   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

   state_t                r_state;
   logic [31:0]           r_ram [2**ADDR_WIDTH];
   logic                  r_rd_q, r_wr_q, r_unsigned;
   logic                  r_mem_ready, r_busy, r_mis_err;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [1:0]            r_len;
   logic [31:0]           r_wdata, r_word, r_rd_data;

   logic                  w_rd_rise, w_wr_rise, w_accept, w_misaligned;
   logic [1:0]            w_len;
   logic [ADDR_WIDTH+1:0] w_addr_al;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_ram_word, w_merged, w_load;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic                  w_unused_addr;

   // Upper address bits are don't-care: accesses wrap modulo the RAM size.
   assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];

   assign w_rd_rise = mem_rd_en & ~r_rd_q;
   assign w_wr_rise = mem_wr_en & ~r_wr_q;
   assign w_accept  = mem_en & (w_rd_rise | w_wr_rise);
   assign w_len     = (data_length == half_word || data_length == byte_word) ? data_length : full_word;

   always_comb begin
      w_addr_al = addr[ADDR_WIDTH+1:0];
      if (w_len == full_word)
         w_addr_al[1:0] = 2'b00;
      else if (w_len == half_word)
         w_addr_al[0] = 1'b0;
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_misaligned = (w_len == half_word && addr[0]) ||
                         (w_len == full_word && addr[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_idx      = r_addr[ADDR_WIDTH+1:2];
   assign w_ram_word = r_ram[w_idx];
   assign w_byte     = w_ram_word[{r_addr[1:0], 3'b000} +: 8];
   assign w_half     = r_addr[1] ? w_ram_word[31:16] : w_ram_word[15:0];

   always_comb begin
      w_load = w_ram_word;
      if (r_len == byte_word)
         w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      else if (r_len == half_word)
         w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
   end

   // Sub-word stores splice the new lane into the word fetched in RMW_RD.
   always_comb begin
      w_merged = r_wdata;
      if (r_len == byte_word) begin
         w_merged = r_word;
         w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end else if (r_len == half_word) begin
         w_merged = r_word;
         if (r_addr[1])
            w_merged[31:16] = r_wdata[15:0];
         else
            w_merged[15:0] = r_wdata[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == WR)
         r_ram[w_idx] <= w_merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rd_q      <= 1'b0;
         r_wr_q      <= 1'b0;
         r_unsigned  <= 1'b0;
         r_mem_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_mis_err   <= 1'b0;
         r_addr      <= '0;
         r_len       <= 2'd0;
         r_wdata     <= 32'd0;
         r_word      <= 32'd0;
         r_rd_data   <= 32'd0;
      end else begin
         r_rd_q      <= mem_rd_en;
         r_wr_q      <= mem_wr_en;
         r_mem_ready <= 1'b0;
         r_mis_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_busy <= w_accept;
               if (w_accept) begin
                  r_addr     <= w_addr_al;
                  r_wdata    <= wr_data;
                  r_len      <= w_len;
                  r_unsigned <= load_unsigned;
                  if (w_misaligned) begin
                     r_state     <= RESP;
                     r_mem_ready <= 1'b1;
                     r_mis_err   <= 1'b1;
                  end else if (w_wr_rise)
                     r_state <= (w_len == full_word) ? WR : RMW_RD;
                  else
                     r_state <= RD;
               end
            end
            RD: begin
               r_rd_data   <= w_load;
               r_state     <= RESP;
               r_mem_ready <= 1'b1;
               r_busy      <= 1'b1;
            end
            RMW_RD: begin
               r_word  <= w_ram_word;
               r_state <= WR;
               r_busy  <= 1'b1;
            end
            WR: begin
               r_state     <= RESP;
               r_mem_ready <= 1'b1;
               r_busy      <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data        = r_rd_data;
   assign mem_ready      = r_mem_ready;
   assign busy           = r_busy;
   assign misaligned_err = r_mis_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench with a behavioural memory model for data_mem_responder
module tb_data_mem_responder;
   localparam int AW = 10;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        mem_en = 1'b0, mem_rd_en = 1'b0, mem_wr_en = 1'b0;
   logic [31:0] addr = 32'd0, wr_data = 32'd0;
   logic [1:0]  data_length = 2'd0;
   logic        load_unsigned = 1'b0;
   logic [31:0] rd_data;
   logic        mem_ready, busy, misaligned_err;

   data_mem_responder #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .addr(addr), .wr_data(wr_data), .data_length(data_length), .load_unsigned(load_unsigned),
      .rd_data(rd_data), .mem_ready(mem_ready), .busy(busy), .misaligned_err(misaligned_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0, errors = 0;
   bit          check_en = 1'b0;
   logic [31:0] model_mem [0:(1<<AW)-1];
   logic [31:0] exp_rd_now = 32'd0, exp_rd_next = 32'd0;
   int          pend_start = -1, pend_ready = -1;
   bit          pend_mis = 1'b0;
   int          ready_count = 0, last_ready_cyc = -1, issue_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         if (cyc == pend_ready) exp_rd_now = exp_rd_next;
         chk("mem_ready", {31'b0, mem_ready}, {31'b0, cyc == pend_ready});
         chk("busy", {31'b0, busy}, {31'b0, pend_start >= 0 && cyc > pend_start && cyc <= pend_ready});
         chk("misaligned_err", {31'b0, misaligned_err}, {31'b0, cyc == pend_ready && pend_mis});
         chk("rd_data", rd_data, exp_rd_now);
         if (mem_ready) begin
            ready_count++;
            last_ready_cyc = cyc;
         end
      end
   end

   task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] len, input bit uns, output int lat, output bit mis);
      int          idx, lane, lenn, width, sh;
      logic [31:0] mask, w, v;
      idx   = int'((a >> 2) % (1 << AW));
      lane  = int'(a & 32'd3);
      lenn  = (len == 2'd3) ? 0 : int'(len);
      width = (lenn == 2) ? 8 : 16;
      sh    = (lenn == 2) ? 8 * lane : 16 * (lane / 2);
      mask  = ((32'd1 << width) - 32'd1) << sh;
      mis   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if ((lenn == 1 && a[0]) || (lenn == 0 && lane != 0)) mis = 1'b1;
`endif
      exp_rd_next = exp_rd_now;
      if (mis) lat = 1;
      else if (wr) begin
         if (lenn == 0) begin
            model_mem[idx] = d;
            lat = 2;
         end else begin
            model_mem[idx] = (model_mem[idx] & ~mask) | ((d << sh) & mask);
            lat = 3;
         end
      end else begin
         w = model_mem[idx];
         if (lenn == 0) v = w;
         else begin
            v = (w >> sh) & ((32'd1 << width) - 32'd1);
            if (!uns && v[width-1]) v = v | ~((32'd1 << width) - 32'd1);
         end
         exp_rd_next = v;
         lat = 2;
      end
   endtask

   task automatic do_op(input bit wr, input bit both, input bit en, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] len, input bit uns,
                        input int hold, input bit noise);
      int guard = 0;
      int lat;
      bit mis;
      do begin
         @(posedge clk); #1;
         guard++;
      end while (cyc < pend_ready + 1 && guard < 100);
      if (guard >= 100) begin
         checks++; errors++;
         $display("FAIL op_start_timeout cyc=%0d required idle by cyc=%0d", cyc, pend_ready + 1);
      end
      mem_en = en; addr = a; wr_data = d; data_length = len; load_unsigned = uns;
      mem_wr_en = wr | both;
      mem_rd_en = !wr | both;
      issue_cyc = cyc;
      if (en) begin
         model_access(wr | both, a, d, len, uns, lat, mis);
         pend_mis   = mis;
         pend_start = cyc;
         pend_ready = cyc + lat;
      end
      for (int h = 1; h < hold; h++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      if (noise && !both && hold == 1) begin
         if (wr) mem_rd_en = 1'b1;
         else    mem_wr_en = 1'b1;
         @(posedge clk); #1;
         mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      end
   endtask

   task automatic wait_done();
      int guard = 0;
      while (cyc <= pend_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         checks++; errors++;
         $display("FAIL done_timeout cyc=%0d required done by cyc=%0d", cyc, pend_ready);
      end
   endtask

   task automatic dir(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] len,
                      input bit uns, input int exp_lat, input logic [31:0] exp_rd, input string name);
      do_op(wr, 1'b0, 1'b1, a, d, len, uns, 1, 1'b0);
      wait_done();
      chk({name, "_latency"}, last_ready_cyc - issue_cyc, exp_lat);
      if (!wr) chk({name, "_rd"}, rd_data, exp_rd);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int          rc0;
      logic [31:0] a;
      int          hold;
      repeat (3) @(negedge clk);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_mem_ready", {31'b0, mem_ready}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_mis", {31'b0, misaligned_err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_en = 1'b1;

      dir(1, 32'h10, 32'hDEADBEEF, 2'd0, 0, 2, 32'h0, "sw_10");
      dir(0, 32'h10, 32'h0, 2'd0, 0, 2, 32'hDEADBEEF, "lw_10");
      dir(1, 32'h13, 32'h80, 2'd2, 0, 3, 32'h0, "sb_13");
      dir(0, 32'h13, 32'h0, 2'd2, 0, 2, 32'hFFFFFF80, "lb_13");
      dir(0, 32'h13, 32'h0, 2'd2, 1, 2, 32'h00000080, "lbu_13");
      dir(0, 32'h10, 32'h0, 2'd0, 0, 2, 32'h80ADBEEF, "lw_10_b");
      dir(1, 32'h12, 32'h1234, 2'd1, 0, 3, 32'h0, "sh_12");
      dir(0, 32'h12, 32'h0, 2'd1, 0, 2, 32'h00001234, "lh_12");
      dir(0, 32'h10, 32'h0, 2'd0, 0, 2, 32'h1234BEEF, "lw_10_c");
      dir(1, 32'h10, 32'h9ABC, 2'd1, 0, 3, 32'h0, "sh_10");
      dir(0, 32'h10, 32'h0, 2'd1, 0, 2, 32'hFFFF9ABC, "lh_10");
      dir(0, 32'h10, 32'h0, 2'd3, 1, 2, 32'h12349ABC, "lw_len3");
`ifdef MEM_MISALIGN_TRAP_EN
      dir(0, 32'h11, 32'h0, 2'd1, 0, 1, 32'h12349ABC, "lh_11_trap");
`else
      dir(0, 32'h11, 32'h0, 2'd1, 0, 2, 32'hFFFF9ABC, "lh_11_align");
`endif

      rc0 = ready_count;
      do_op(0, 0, 1, 32'h10, 32'h0, 2'd0, 0, 8, 0);
      wait_done();
      chk("held_strobe_once", ready_count - rc0, 32'd1);
      do_op(0, 0, 1, 32'h10, 32'h0, 2'd0, 0, 1, 0);
      wait_done();
      chk("reraise_second", ready_count - rc0, 32'd2);
      do_op(0, 0, 0, 32'h10, 32'h0, 2'd0, 0, 1, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("mem_en_low_ignored", ready_count - rc0, 32'd2);

      check_en = 1'b0;
      mem_en = 1'b1; addr = 32'h10; wr_data = 32'hFF; data_length = 2'd2; mem_wr_en = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy_before", {31'b0, busy}, 32'd1);
      rst_n = 1'b0; mem_wr_en = 1'b0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_no_ready", {31'b0, mem_ready}, 32'd0);
      end
      rst_n = 1'b1;
      exp_rd_now = 32'd0; pend_start = -1; pend_ready = -1; pend_mis = 1'b0;
      check_en = 1'b1;
      dir(0, 32'h10, 32'h0, 2'd0, 0, 2, 32'h12349ABC, "rst_keep_lw");

      for (int i = 0; i < 16; i++)
         do_op(1, 0, 1, 32'(i * 4), $urandom, 2'd0, 0, 1, 0);

      for (int n = 0; n < 250; n++) begin
         a = ($urandom & 32'hFFFFF000) | (($urandom % 16) << 2) | ($urandom % 4);
         hold = ($urandom % 8 == 0) ? 8 : int'($urandom_range(1, 3));
         do_op($urandom % 2 == 1, $urandom % 8 == 0, $urandom % 8 != 0, a, $urandom,
               2'($urandom % 4), $urandom % 2 == 1, hold, $urandom % 4 == 0);
      end
      wait_done();
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
